// File: rtl/snake_pkg.sv
// Shared definitions for the snake step engine: cell codes, directions,
// grid geometry and the controller state encoding.
package snake_pkg;

    localparam int GRID = 16;

    localparam logic [3:0] CELL_EMPTY = 4'hE;
    localparam logic [3:0] CELL_FOOD  = 4'hF;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [7:0] MAX_LEN = 8'd255;

    typedef enum logic [3:0] {
        INIT_CLR,
        INIT_BODY,
        FEED,
        IDLE,
        RD_HEAD,
        CHK,
        WR_OLD,
        WR_NEW,
        RD_TAIL,
        TL_CHK,
        ERASE,
        OVER
    } state_t;

endpackage

// File: rtl/snake_nextpos.sv
// Neighbour-cell calculator on the 16x16 grid.
// Edge behaviour: SNAKE_WRAP_EN defined wraps, undefined flags off_grid.
module snake_nextpos
    import snake_pkg::*;
(
    input  logic [7:0] pos,
    input  logic [1:0] dir,
    output logic [7:0] next,
    output logic       off_grid
);

`ifdef SNAKE_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    logic [3:0] row;
    logic [3:0] col;
    logic       edge_hit;

    always_comb begin
        row      = pos[7:4];
        col      = pos[3:0];
        edge_hit = 1'b0;
        unique case (dir)
            DIR_UP: begin
                row      = pos[7:4] - 4'd1;
                edge_hit = (pos[7:4] == 4'd0);
            end
            DIR_DOWN: begin
                row      = pos[7:4] + 4'd1;
                edge_hit = (pos[7:4] == 4'd15);
            end
            DIR_LEFT: begin
                col      = pos[3:0] - 4'd1;
                edge_hit = (pos[3:0] == 4'd0);
            end
            default: begin
                col      = pos[3:0] + 4'd1;
                edge_hit = (pos[3:0] == 4'd15);
            end
        endcase
    end

    assign next     = {row, col};
    assign off_grid = edge_hit & ~WRAP;

endmodule

// File: rtl/snake_step.sv
// Snake game step controller driving a 16x16 map through a single port.
// SNAKE_WRAP_EN selects wrap-around edges instead of edge collisions.
module snake_step
    import snake_pkg::*;
#(
    parameter int INIT_LEN = 3,
    parameter int INIT_ROW = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] dir_in,
    output logic [7:0] mem_addr,
    output logic       mem_re,
    output logic       mem_we,
    output logic [3:0] mem_wdata,
    input  logic [3:0] mem_rdata,
    output logic       generate_food,
    input  logic       food_placed,
    output logic       bus_own,
    output logic [7:0] length,
    output logic       game_over,
    output logic       win
);

    localparam logic [3:0] ROW   = 4'(INIT_ROW);
    localparam logic [7:0] HEAD0 = {ROW, 4'(4 + INIT_LEN - 1)};
    localparam logic [7:0] TAIL0 = {ROW, 4'd4};

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] head;
    logic [7:0] tail;
    logic [1:0] dir;
    logic [1:0] tail_dir;
    logic       eat;
    logic       win_q;

    logic [7:0] np_pos;
    logic [1:0] np_dir;
    logic [7:0] np_next;
    logic       np_off;

    // One calculator serves the head, except while erasing the tail.
    assign np_pos = (state == ERASE) ? tail : head;
    assign np_dir = (state == ERASE) ? tail_dir : dir;

    snake_nextpos u_nextpos (
        .pos      (np_pos),
        .dir      (np_dir),
        .next     (np_next),
        .off_grid (np_off)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT_CLR;
            cnt      <= '0;
            head     <= HEAD0;
            tail     <= TAIL0;
            dir      <= DIR_RIGHT;
            tail_dir <= DIR_RIGHT;
            length   <= 8'(INIT_LEN);
            eat      <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == INIT_CLR || state == INIT_BODY) begin
                if (state_nx != state) cnt <= '0;
                else                   cnt <= cnt + 8'd1;
            end
            if (state == IDLE && tick && dir_in != (dir ^ 2'b01))
                dir <= dir_in;
            if (state == CHK)
                eat <= (mem_rdata == CELL_FOOD);
            if (state == WR_NEW) begin
                head <= np_next;
                if (eat) length <= length + 8'd1;
                if (eat && length == MAX_LEN - 8'd1) win_q <= 1'b1;
            end
            if (state == TL_CHK)
                tail_dir <= mem_rdata[1:0];
            if (state == ERASE)
                tail <= np_next;
        end
    end

    always_comb begin
        state_nx      = state;
        mem_addr      = '0;
        mem_re        = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = CELL_EMPTY;
        generate_food = 1'b0;
        bus_own       = 1'b1;
        unique case (state)
            INIT_CLR: begin
                mem_we   = 1'b1;
                mem_addr = cnt;
                if (cnt == 8'hFF) state_nx = INIT_BODY;
            end
            INIT_BODY: begin
                mem_we    = 1'b1;
                mem_addr  = {ROW, 4'd4 + cnt[3:0]};
                mem_wdata = {2'b00, DIR_RIGHT};
                if (cnt == 8'(INIT_LEN - 1)) state_nx = FEED;
            end
            FEED: begin
                generate_food = 1'b1;
                bus_own       = 1'b0;
                if (food_placed) state_nx = IDLE;
            end
            IDLE: begin
                if (tick) state_nx = RD_HEAD;
            end
            RD_HEAD: begin
                if (np_off) begin
                    state_nx = OVER;
                end else begin
                    mem_re   = 1'b1;
                    mem_addr = np_next;
                    state_nx = CHK;
                end
            end
            CHK: begin
                if (mem_rdata == CELL_EMPTY || mem_rdata == CELL_FOOD)
                    state_nx = WR_OLD;
                else
                    state_nx = OVER;
            end
            WR_OLD: begin
                mem_we    = 1'b1;
                mem_addr  = head;
                mem_wdata = {2'b00, dir};
                state_nx  = WR_NEW;
            end
            WR_NEW: begin
                mem_we    = 1'b1;
                mem_addr  = np_next;
                mem_wdata = {2'b00, dir};
                if (!eat)
                    state_nx = RD_TAIL;
                else if (length == MAX_LEN - 8'd1)
                    state_nx = OVER;
                else
                    state_nx = FEED;
            end
            RD_TAIL: begin
                mem_re   = 1'b1;
                mem_addr = tail;
                state_nx = TL_CHK;
            end
            TL_CHK: begin
                state_nx = ERASE;
            end
            ERASE: begin
                mem_we   = 1'b1;
                mem_addr = tail;
                state_nx = IDLE;
            end
            OVER: begin
                state_nx = OVER;
            end
            default: begin
                state_nx = INIT_CLR;
            end
        endcase
        // Outputs read as idle while reset is being applied.
        if (rst) begin
            mem_re        = 1'b0;
            mem_we        = 1'b0;
            generate_food = 1'b0;
        end
    end

    assign game_over = (state == OVER) && !rst;
    assign win       = win_q && !rst;

endmodule
